// File: rtl/freq_meter_gate.sv
// freq_meter_gate: counts rising edges of an asynchronous sig_in over a fixed window
// of GATE_CYCLES refclk cycles and hands the count downstream over valid/ready.
// Optional build macro FREQ_METER_AUTORESTART_EN: after each result handshake a new
// window opens immediately (continuous measurement) until abort returns to IDLE.
module freq_meter_gate #(
    parameter int unsigned GATE_CYCLES = 50000000,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             refclk,
    input  logic             rst_n,
    input  logic             sig_in,
    input  logic             start,
    input  logic             abort,
    output logic             busy,
    output logic [CNT_W-1:0] result,
    output logic             result_valid,
    input  logic             result_ready,
    output logic             overflow
);

    localparam int unsigned GATE_W = $clog2(GATE_CYCLES);
    localparam logic [GATE_W-1:0] GATE_LOAD = GATE_W'(GATE_CYCLES - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] GATE = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    logic [1:0]             state;
    logic [1:0]             state_nxt;
    logic [GATE_W-1:0]      gate_cnt;
    logic [GATE_W-1:0]      gate_cnt_nxt;
    logic [CNT_W-1:0]       edge_cnt;
    logic [CNT_W-1:0]       edge_cnt_nxt;
    logic [CNT_W-1:0]       result_nxt;
    logic                   valid_nxt;
    logic                   overflow_nxt;
    logic                   busy_nxt;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sig_d;
    logic                   sig_s;
    logic                   rise;
    logic                   at_max;
    logic                   sat_hit;
    logic [CNT_W-1:0]       edge_sum;
    logic                   restart;

    // Synchronized level and its one-cycle rising-edge pulse
    assign sig_s = sync_q[SYNC_STAGES-1];
    assign rise  = sig_s & ~sig_d;

    // Saturating edge accumulation; an edge arriving at all-ones is lost and flagged
    assign at_max   = &edge_cnt;
    assign sat_hit  = at_max & rise;
    assign edge_sum = at_max ? edge_cnt : edge_cnt + CNT_W'(rise);

    // Whether a completed handshake immediately opens the next window
`ifdef FREQ_METER_AUTORESTART_EN
    assign restart = 1'b1;
`else
    assign restart = start;
`endif

    // Next-state and next-value logic; abort overrides everything
    always_comb begin
        state_nxt    = state;
        gate_cnt_nxt = gate_cnt;
        edge_cnt_nxt = edge_cnt;
        result_nxt   = result;
        valid_nxt    = result_valid;
        overflow_nxt = overflow;

        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt    = GATE;
                    gate_cnt_nxt = GATE_LOAD;
                    edge_cnt_nxt = '0;
                    overflow_nxt = 1'b0;
                end
            end
            GATE: begin
                edge_cnt_nxt = edge_sum;
                if (sat_hit) begin
                    overflow_nxt = 1'b1;
                end
                gate_cnt_nxt = gate_cnt - GATE_W'(1);
                if (gate_cnt == '0) begin
                    gate_cnt_nxt = '0;
                    result_nxt   = edge_sum;
                    valid_nxt    = 1'b1;
                    state_nxt    = HOLD;
                end
            end
            HOLD: begin
                if (result_valid && result_ready) begin
                    valid_nxt = 1'b0;
                    if (restart) begin
                        state_nxt    = GATE;
                        gate_cnt_nxt = GATE_LOAD;
                        edge_cnt_nxt = '0;
                        overflow_nxt = 1'b0;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (abort) begin
            state_nxt    = IDLE;
            valid_nxt    = 1'b0;
            gate_cnt_nxt = '0;
            edge_cnt_nxt = '0;
            overflow_nxt = 1'b0;
        end

        busy_nxt = (state_nxt != IDLE);
    end

    // State, counters, registered outputs and the sig_in synchronizer
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            gate_cnt     <= '0;
            edge_cnt     <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            overflow     <= 1'b0;
            busy         <= 1'b0;
            sync_q       <= '0;
            sig_d        <= 1'b0;
        end else begin
            state        <= state_nxt;
            gate_cnt     <= gate_cnt_nxt;
            edge_cnt     <= edge_cnt_nxt;
            result       <= result_nxt;
            result_valid <= valid_nxt;
            overflow     <= overflow_nxt;
            busy         <= busy_nxt;
            sync_q       <= {sync_q[SYNC_STAGES-2:0], sig_in};
            sig_d        <= sig_s;
        end
    end

endmodule

// File: tb/tb_freq_meter_gate.sv
// Directed bench for freq_meter_gate: window count, static input, saturation,
// backpressure, abort, reset, and (with FREQ_METER_AUTORESTART_EN) continuous mode.
module tb_freq_meter_gate;

`ifdef FREQ_METER_AUTORESTART_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic        refclk;
    logic        rst_n;
    logic        sig_in;
    logic        start;
    logic        abort;
    logic        ready;
    logic        busy;
    logic [31:0] result;
    logic        valid;
    logic        ovf;
    logic        start4;
    logic        ready4;
    logic        busy4;
    logic [3:0]  result4;
    logic        valid4;
    logic        ovf4;

    int total = 0;
    int bad   = 0;
    int sig_half = 0;
    logic sig_level = 1'b0;

    freq_meter_gate #(.GATE_CYCLES(1000), .CNT_W(32), .SYNC_STAGES(2)) dut (
        .refclk(refclk), .rst_n(rst_n), .sig_in(sig_in), .start(start), .abort(abort),
        .busy(busy), .result(result), .result_valid(valid), .result_ready(ready),
        .overflow(ovf)
    );

    freq_meter_gate #(.GATE_CYCLES(1000), .CNT_W(4), .SYNC_STAGES(2)) dut4 (
        .refclk(refclk), .rst_n(rst_n), .sig_in(sig_in), .start(start4), .abort(abort),
        .busy(busy4), .result(result4), .result_valid(valid4), .result_ready(ready4),
        .overflow(ovf4)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    // Test signal: square wave toggling every sig_half cycles, or a static level
    initial begin
        int ph;
        ph = 0;
        sig_in = 1'b0;
        forever begin
            @(negedge refclk);
            if (sig_half != 0) begin
                ph++;
                if (ph >= sig_half) begin
                    ph = 0;
                    sig_in = ~sig_in;
                end
            end else begin
                sig_in = sig_level;
            end
        end
    end

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge refclk);
    endtask

    // Pulse start on the main instance and count negedges until result_valid
    task automatic run_window(output int cyc, output bit timed_out);
        @(negedge refclk); start = 1'b1;
        @(negedge refclk); start = 1'b0;
        cyc = 1;
        while (!valid && cyc < 3000) begin
            @(negedge refclk);
            cyc++;
        end
        timed_out = !valid;
    endtask

    task automatic run_window4(output int cyc, output bit timed_out);
        @(negedge refclk); start4 = 1'b1;
        @(negedge refclk); start4 = 1'b0;
        cyc = 1;
        while (!valid4 && cyc < 3000) begin
            @(negedge refclk);
            cyc++;
        end
        timed_out = !valid4;
    endtask

    task automatic pulse_abort();
        @(negedge refclk); abort = 1'b1;
        @(negedge refclk); abort = 1'b0;
    endtask

    // Accept the pending result, then make sure the meter is back in IDLE
    task automatic finish_handshake(input string name);
        @(negedge refclk); ready = 1'b1;
        @(negedge refclk); ready = 1'b0;
        total++;
        if (valid !== 1'b0) begin
            bad++;
            $display("FAIL %s_valid_drop: got %0b expected 0", name, valid);
        end
        if (AUTO) pulse_abort();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_cycles(3);
        total++; if (busy !== 1'b0)  begin bad++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        total++; if (result !== 32'd0) begin bad++; $display("FAIL reset_result: got %0d expected 0", result); end
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %0b expected 0", valid); end
        total++; if (ovf !== 1'b0)   begin bad++; $display("FAIL reset_ovf: got %0b expected 0", ovf); end
        @(negedge refclk); rst_n = 1'b1;
        idle_cycles(2);
    endtask

    task automatic test_basic();
        int cyc;
        bit to;
        sig_half = 2;
        idle_cycles(10);
        run_window(cyc, to);
        total++; if (to) begin bad++; $display("FAIL basic_timeout: got valid=0 expected 1"); end
        // 1000 gate cycles plus the cycle in which start is sampled
        total++; if (cyc != 1001) begin bad++; $display("FAIL basic_latency: got %0d expected 1001", cyc); end
        total++; if (result !== 32'd250) begin bad++; $display("FAIL basic_result: got %0d expected 250", result); end
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL basic_ovf: got %0b expected 0", ovf); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy_hold: got %0b expected 1", busy); end
    endtask

    task automatic test_hold_backpressure();
        bit stable;
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge refclk);
            start = (i == 5);
            if (valid !== 1'b1 || result !== 32'd250 || busy !== 1'b1) stable = 1'b0;
        end
        @(negedge refclk); start = 1'b0;
        total++; if (!stable) begin bad++; $display("FAIL hold_stable: got 0 expected 1"); end
        ready = 1'b1;
        @(negedge refclk); ready = 1'b0;
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL hold_valid_drop: got %0b expected 0", valid); end
        total++; if (busy !== AUTO) begin bad++; $display("FAIL hold_busy_after: got %0b expected %0b", busy, AUTO); end
        total++; if (result !== 32'd250) begin bad++; $display("FAIL hold_result_persist: got %0d expected 250", result); end
        if (AUTO) pulse_abort();
        idle_cycles(5);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL hold_idle: got %0b expected 0", busy); end
    endtask

    task automatic test_abort_reset();
        bit saw;
        @(negedge refclk); start = 1'b1;
        @(negedge refclk); start = 1'b0;
        idle_cycles(499);
        abort = 1'b1;
        @(negedge refclk); abort = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy: got %0b expected 0", busy); end
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL abort_valid: got %0b expected 0", valid); end
        total++; if (result !== 32'd250) begin bad++; $display("FAIL abort_result_kept: got %0d expected 250", result); end
        saw = 1'b0;
        for (int i = 0; i < 1100; i++) begin
            @(negedge refclk);
            if (valid) saw = 1'b1;
        end
        total++; if (saw) begin bad++; $display("FAIL abort_no_result: got 1 expected 0"); end
        @(negedge refclk); start = 1'b1;
        @(negedge refclk); start = 1'b0;
        idle_cycles(300);
        rst_n = 1'b0;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midreset_busy: got %0b expected 0", busy); end
        total++; if (result !== 32'd0) begin bad++; $display("FAIL midreset_result: got %0d expected 0", result); end
        total++; if (valid !== 1'b0 || ovf !== 1'b0) begin bad++; $display("FAIL midreset_flags: got %0b%0b expected 00", valid, ovf); end
        @(negedge refclk); rst_n = 1'b1;
        idle_cycles(3);
    endtask

    task automatic test_static();
        int cyc;
        bit to;
        sig_half = 0;
        sig_level = 1'b0;
        idle_cycles(10);
        run_window(cyc, to);
        total++; if (to || result !== 32'd0) begin bad++; $display("FAIL static_low: got %0d expected 0", result); end
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL static_low_ovf: got %0b expected 0", ovf); end
        finish_handshake("static_low");
        sig_level = 1'b1;
        idle_cycles(10);
        run_window(cyc, to);
        total++; if (to || result !== 32'd0) begin bad++; $display("FAIL static_high: got %0d expected 0", result); end
        finish_handshake("static_high");
    endtask

    task automatic test_saturate();
        int cyc;
        bit to;
        sig_half = 4;
        idle_cycles(10);
        run_window4(cyc, to);
        total++; if (to || result4 !== 4'd15) begin bad++; $display("FAIL sat_result: got %0d expected 15", result4); end
        total++; if (ovf4 !== 1'b1) begin bad++; $display("FAIL sat_ovf: got %0b expected 1", ovf4); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL sat_main_idle: got %0b expected 0", busy); end
        @(negedge refclk); ready4 = 1'b1;
        @(negedge refclk); ready4 = 1'b0;
        total++; if (valid4 !== 1'b0) begin bad++; $display("FAIL sat_valid_drop: got %0b expected 0", valid4); end
        if (AUTO) pulse_abort();
    endtask

    task automatic test_start_abort_idle();
        @(negedge refclk); start = 1'b1; abort = 1'b1;
        @(negedge refclk); start = 1'b0; abort = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL start_abort_idle: got %0b expected 0", busy); end
        idle_cycles(3);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL start_abort_stay: got %0b expected 0", busy); end
    endtask

`ifdef FREQ_METER_AUTORESTART_EN
    task automatic test_autorestart();
        int cyc;
        bit to;
        sig_half = 2;
        ready = 1'b1;
        idle_cycles(10);
        run_window(cyc, to);
        total++; if (to || result !== 32'd250) begin bad++; $display("FAIL auto_first: got %0d expected 250", result); end
        for (int k = 0; k < 3; k++) begin
            cyc = 0;
            do begin
                @(negedge refclk);
                cyc++;
            end while (!valid && cyc < 3000);
            total++; if (cyc != 1001) begin bad++; $display("FAIL auto_interval%0d: got %0d expected 1001", k, cyc); end
            total++; if (result !== 32'd250) begin bad++; $display("FAIL auto_result%0d: got %0d expected 250", k, result); end
        end
        ready = 1'b0;
        pulse_abort();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL auto_abort: got %0b expected 0", busy); end
        idle_cycles(1100);
        total++; if (busy !== 1'b0 || valid !== 1'b0) begin bad++; $display("FAIL auto_stopped: got %0b%0b expected 00", busy, valid); end
    endtask
`endif

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        abort  = 1'b0;
        ready  = 1'b0;
        start4 = 1'b0;
        ready4 = 1'b0;
        test_reset();
        test_basic();
        test_hold_backpressure();
        test_abort_reset();
        test_static();
        test_saturate();
        test_start_abort_idle();
`ifdef FREQ_METER_AUTORESTART_EN
        test_autorestart();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
